// File: rtl/mul_pkg.sv
// Shared definitions for the pipelined M-extension multiplier: op encoding and
// per-op operand signedness.
package mul_pkg;

  localparam int unsigned MUL_OP_W = 2;

  typedef enum logic [MUL_OP_W-1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_e;

  typedef struct packed {
    logic a;
    logic b;
  } mul_sign_t;

  function automatic mul_sign_t op_signedness(mul_op_e op);
    mul_sign_t s;
    s.a = (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
    s.b = (op == MUL_OP_MULH);
    return s;
  endfunction

endpackage

// File: rtl/mul_pipe_if.sv
// Request/response handshake bundle of mul_pipe; slave is the multiplier side.
interface mul_pipe_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
);
  import mul_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [MUL_OP_W-1:0] in_op;
  logic [XLEN-1:0]     in_a;
  logic [XLEN-1:0]     in_b;
  logic [TAG_W-1:0]    in_tag;
  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     out_result;
  logic [TAG_W-1:0]    out_tag;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );

endinterface

// File: rtl/mul_core.sv
// Combinational multiply datapath: operand extension, (XLEN+1)-bit signed
// product truncated to 2*XLEN, and high/low half select.
module mul_core
  import mul_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  mul_op_e           ext_op,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [XLEN:0]     a_ext,
  output logic [XLEN:0]     b_ext,
  input  logic [XLEN:0]     mul_a,
  input  logic [XLEN:0]     mul_b,
  output logic [2*XLEN-1:0] prod,
  input  mul_op_e           sel_op,
  input  logic [2*XLEN-1:0] sel_prod,
  output logic [XLEN-1:0]   result
);

  mul_sign_t                sgn;
  logic signed [2*XLEN-1:0] wide_a;
  logic signed [2*XLEN-1:0] wide_b;

  always_comb begin
    sgn   = op_signedness(ext_op);
    a_ext = {sgn.a & a[XLEN-1], a};
    b_ext = {sgn.b & b[XLEN-1], b};
  end

  // Low 2*XLEN bits of the product of the sign-extended (XLEN+1)-bit operands.
  always_comb begin
    wide_a = {{(XLEN-1){mul_a[XLEN]}}, mul_a};
    wide_b = {{(XLEN-1){mul_b[XLEN]}}, mul_b};
    prod   = wide_a * wide_b;
  end

  always_comb begin
    result = (sel_op == MUL_OP_MUL) ? sel_prod[XLEN-1:0] : sel_prod[2*XLEN-1:XLEN];
  end

endmodule

// File: rtl/mul_pipe.sv
// Pipelined MUL/MULH/MULHSU/MULHU unit with valid/ready flow control and tags.
// Optional synchronous flush of in-flight work when MUL_PIPE_FLUSH_EN is defined.
module mul_pipe
  import mul_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STAGES = 3,
  parameter int unsigned TAG_W  = 5
) (
  input logic       clk,
  input logic       rstn,
  input logic       flush,
  mul_pipe_if.slave bus
);

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] ld;
  logic              kill;
  logic              in_rdy;
  logic              acc;

  logic [XLEN:0]     a_q, b_q;
  logic [XLEN:0]     a_ext, b_ext;
  logic [TAG_W-1:0]  tag_q [STAGES];
  mul_op_e           op_q  [STAGES-1];
  logic [XLEN-1:0]   res_q;
  logic [XLEN-1:0]   result;
  logic [2*XLEN-1:0] prod_c;
  logic [2*XLEN-1:0] prod_sel;

`ifdef MUL_PIPE_FLUSH_EN
  assign kill = flush;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign kill         = 1'b0;
`endif

  // Stage i loads unless it and every stage after it are full while out_ready is low.
  always_comb begin
    logic tail_full;
    ld        = '0;
    tail_full = 1'b1;
    for (int unsigned k = 0; k < STAGES; k++) begin
      tail_full           = tail_full & vld[STAGES-1-k];
      ld[STAGES-1-k]      = bus.out_ready | ~tail_full;
    end
  end

  assign in_rdy = ld[0] & ~kill;
  assign acc    = bus.in_valid & in_rdy;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld <= '0;
    end else if (kill) begin
      vld <= '0;
    end else begin
      if (ld[0]) vld[0] <= acc;
      for (int unsigned i = 1; i < STAGES; i++) begin
        if (ld[i]) vld[i] <= vld[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      for (int unsigned i = 0; i < STAGES; i++) tag_q[i] <= '0;
      for (int unsigned i = 0; i < STAGES-1; i++) op_q[i] <= MUL_OP_MUL;
    end else begin
      if (ld[0]) begin
        a_q      <= a_ext;
        b_q      <= b_ext;
        op_q[0]  <= mul_op_e'(bus.in_op);
        tag_q[0] <= bus.in_tag;
      end
      for (int unsigned i = 1; i < STAGES; i++) begin
        if (ld[i]) tag_q[i] <= tag_q[i-1];
      end
      for (int unsigned i = 1; i < STAGES-1; i++) begin
        if (ld[i]) op_q[i] <= op_q[i-1];
      end
      if (ld[STAGES-1]) res_q <= result;
    end
  end

  // Product registers between stage 0 and the select mux; absent when STAGES == 2.
  if (STAGES > 2) begin : g_mid
    logic [2*XLEN-1:0] p_q [1:STAGES-2];

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int unsigned i = 1; i <= STAGES-2; i++) p_q[i] <= '0;
      end else begin
        if (ld[1]) p_q[1] <= prod_c;
        for (int unsigned i = 2; i <= STAGES-2; i++) begin
          if (ld[i]) p_q[i] <= p_q[i-1];
        end
      end
    end

    assign prod_sel = p_q[STAGES-2];
  end else begin : g_direct
    assign prod_sel = prod_c;
  end

  mul_core #(
    .XLEN(XLEN)
  ) u_core (
    .ext_op   (mul_op_e'(bus.in_op)),
    .a        (bus.in_a),
    .b        (bus.in_b),
    .a_ext    (a_ext),
    .b_ext    (b_ext),
    .mul_a    (a_q),
    .mul_b    (b_q),
    .prod     (prod_c),
    .sel_op   (op_q[STAGES-2]),
    .sel_prod (prod_sel),
    .result   (result)
  );

  assign bus.in_ready   = in_rdy;
  assign bus.out_valid  = vld[STAGES-1];
  assign bus.out_result = res_q;
  assign bus.out_tag    = tag_q[STAGES-1];

endmodule

// File: tb/tb_mul_pipe.sv
// Scoreboard bench for mul_pipe (XLEN=32, STAGES=3); flush expectations follow
// MUL_PIPE_FLUSH_EN.
module tb_mul_pipe;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned STAGES = 3;
  localparam int unsigned TAG_W  = 5;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  res;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  logic flush;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   last_acc = 0;
  exp_t sbq[$];
  int   pop_cyc[$];

  mul_pipe_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  mul_pipe #(
    .XLEN   (XLEN),
    .STAGES (STAGES),
    .TAG_W  (TAG_W)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0]        za, zb, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    za = {32'b0, a};
    zb = {32'b0, b};
    case (op)
      2'd0:    p = za * zb;
      2'd1:    p = sa * sb;
      2'd2:    p = sa * zb;
      default: p = za * zb;
    endcase
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  // Output monitor: pops on each out transfer, checks hold stability under stall.
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.out_valid && bus.out_ready) begin
        check("sb_nonempty", 64'(sbq.size() != 0), 1);
        if (sbq.size() != 0) begin
          exp_t e;
          e = sbq.pop_front();
          check("out_tag", bus.out_tag, e.tag);
          check("out_result", bus.out_result, e.res);
          pop_cyc.push_back(cyc);
        end
      end else if (bus.out_valid && sbq.size() != 0) begin
        check("stall_tag", bus.out_tag, sbq[0].tag);
        check("stall_result", bus.out_result, sbq[0].res);
      end
`ifdef MUL_PIPE_FLUSH_EN
      if (flush) sbq.delete();
`endif
    end
  end

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag, input logic [31:0] exp);
    int unsigned n;
    bit          ok;
    exp_t        e;
    n  = 0;
    ok = 0;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1;
      else n++;
    end
    if (ok) begin
      e.tag = tag;
      e.res = exp;
      sbq.push_back(e);
      last_acc = cyc;
    end else begin
      check("send_timeout", 0, 1);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while ((sbq.size() != 0 || bus.out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", 64'(sbq.size()), 0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    check("watchdog", 1, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  rop;

    rstn          = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_result", bus.out_result, 0);
    check("rst_out_tag", bus.out_tag, 0);
    check("rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Signed low product with latency
    pop_cyc.delete();
    send(2'd0, 32'd7, 32'hFFFF_FFFD, 5'd4, 32'hFFFF_FFEB);
    drain();
    check("lat_pops", 64'(pop_cyc.size()), 1);
    if (pop_cyc.size() == 1) check("latency", 64'(pop_cyc[0] - last_acc), STAGES);

    // High products
    send(2'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000);
    send(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE);
    send(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF);
    send(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'h0000_0000);
    drain();

    // Back-to-back streaming
    pop_cyc.delete();
    for (int unsigned t = 0; t < 8; t++) begin
      ra  = $urandom;
      rb  = $urandom;
      rop = 2'($urandom_range(0, 3));
      send(rop, ra, rb, 5'(t), ref_mul(rop, ra, rb));
    end
    drain();
    check("stream_pops", 64'(pop_cyc.size()), 8);
    for (int unsigned i = 1; i < 8 && i < pop_cyc.size(); i++)
      check("stream_gap", 64'(pop_cyc[i] - pop_cyc[i-1]), 1);

    // Backpressure: three fill the pipe, the fourth is refused until out_ready rises
    bus.out_ready = 1'b0;
    send(2'd0, 32'd11, 32'd13, 5'd21, 32'd143);
    send(2'd3, 32'hDEAD_BEEF, 32'h1234_5678, 5'd22, ref_mul(2'd3, 32'hDEAD_BEEF, 32'h1234_5678));
    send(2'd2, 32'h8765_4321, 32'h0F0F_0F0F, 5'd23, ref_mul(2'd2, 32'h8765_4321, 32'h0F0F_0F0F));
    bus.in_valid = 1'b1;
    bus.in_op    = 2'd1;
    bus.in_a     = 32'hFFFF_FF00;
    bus.in_b     = 32'h0000_0100;
    bus.in_tag   = 5'd24;
    @(negedge clk);
    check("bp_in_ready_0", bus.in_ready, 0);
    @(negedge clk);
    check("bp_in_ready_1", bus.in_ready, 0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(2'd1, 32'hFFFF_FF00, 32'h0000_0100, 5'd24, 32'hFFFF_FFFF);
    send(2'd0, 32'h0001_0000, 32'h0001_0000, 5'd25, 32'h0000_0000);
    drain();

    // Flush with two operations in flight
    send(2'd0, 32'd2, 32'd3, 5'd10, 32'd6);
    send(2'd0, 32'd4, 32'd5, 5'd11, 32'd20);
    flush = 1'b1;
`ifdef MUL_PIPE_FLUSH_EN
    bus.in_valid = 1'b1;
    bus.in_op    = 2'd0;
    bus.in_a     = 32'd9;
    bus.in_b     = 32'd9;
    bus.in_tag   = 5'd13;
    @(negedge clk);
    check("flush_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", bus.out_valid, 0);
    repeat (5) @(negedge clk);
`else
    @(negedge clk);
    check("noflush_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    flush = 1'b0;
`endif
    send(2'd3, 32'h0000_0003, 32'h8000_0000, 5'd12, 32'h0000_0001);
    drain();

    // Reset with three operations in flight
    bus.out_ready = 1'b0;
    send(2'd0, 32'd100, 32'd3, 5'd17, 32'd300);
    send(2'd0, 32'd200, 32'd3, 5'd18, 32'd600);
    send(2'd0, 32'd300, 32'd3, 5'd19, 32'd900);
    rstn = 1'b0;
    sbq.delete();
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_out_result", bus.out_result, 0);
    check("mid_rst_out_tag", bus.out_tag, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    send(2'd0, 32'd3, 32'd5, 5'd7, 32'h0000_000F);
    drain();

    check("final_sb_empty", 64'(sbq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
